grid_scan_driver: RTL and testbench
===================================

// Module: grid_scan_driver
// PURPOSE
//  Reads the 64-bit life grid from the generation controller and scans it onto an 8x8 LED matrix.
//  Drives one row at a time: one-hot row select plus 8 column bits. Refreshes continuously.
//  A new grid is captured into a pending buffer and swapped into the display buffer only at a
//  frame boundary, so a frame never shows two generations. Sits between control and board pins.
// PARAMETERS
//  ROW_DWELL     4  clock cycles each row is lit (>=1)
//  BLANK_CYCLES  1  dark cycles after each row, for anti-ghosting (>=0)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low
//  enable      in   1   1 = scanning allowed; sampled only at a frame boundary
//  grid        in   64  grid word; row r = grid[8r+7:8r], column c = grid[8r+c]
//  grid_valid  in   1   1-cycle strobe: grid holds a new generation
//  row_sel     out  8   one-hot active-high row drive; 0 = all rows dark
//  col_data    out  8   column drive for the selected row
//  frame_done  out  1   1-cycle pulse when row 7 completes
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, row_sel=0, col_data=0, frame_done=0, busy=0, pending=0, both buffers=0.
//  - All outputs are registered. There are no combinational input-to-output paths.
//  - Capture: at any edge where grid_valid=1, pend_buf<=grid and pending<=1. A later strobe
//    overwrites the earlier value, so only the last generation is kept.
//  - IDLE: if pending && enable -> LOAD. Outputs stay dark.
//  - LOAD (1 cycle): disp_buf<=pend_buf, pending<=0, row<=0 -> SHOW.
//    If grid_valid is high in this same cycle, the capture wins: pending stays 1 with the new value.
//  - SHOW: row_sel=1<<row, col_data=disp_buf row. Hold ROW_DWELL cycles.
//    Then go to BLANK, or straight to the next row if BLANK_CYCLES==0.
//  - BLANK: row_sel=0, col_data=0 for BLANK_CYCLES cycles, then go to the next row.
//  - End of row 7: frame_done=1 for one cycle, then:
//    - pending && enable -> LOAD
//    - !enable -> IDLE (dark)
//    - otherwise wrap to row 0 with the same disp_buf.
//  - Latency: grid_valid sampled at edge N; from IDLE, row 0 is driven from edge N+2.
//  - Frame period: 8*(ROW_DWELL+BLANK_CYCLES) cycles, plus 1 cycle if a LOAD occurs.
//  - enable deasserted mid-frame: the current frame completes. It is never cut short.
//  - Reset asserted mid-frame: outputs go dark immediately (async) and the pending grid is lost.
//  - Counters: row is 3 bits. The dwell counter is $clog2(max(ROW_DWELL,BLANK_CYCLES)+1) bits and
//    reloads on every state change; it does not wrap arbitrarily.
// CONFIGURATION
//  LED_DIM_EN defined:
//    - adds input duty [$clog2(ROW_DWELL+1)-1:0].
//    - col_data is driven only in the first `duty` cycles of each SHOW dwell; 0 for the rest.
//    - duty>=ROW_DWELL means full brightness. duty=0 means dark columns; row_sel still scans.
//    - duty is sampled at each row start.
//  LED_DIM_EN undefined: no duty port; columns are lit for the full dwell.
// STRUCTURE
//  - Package grid_pkg holds:
//    - GRID_ROWS=8, GRID_COLS=8
//    - typedef logic [63:0] grid_t
//    - typedef enum {IDLE,LOAD,SHOW,BLANK} scan_state_t
//  - One sub-module, scan_timer:
//    - loadable down-counter with a terminal-count flag, used for both dwell and blank.
//  - The FSM, buffers and row decode stay in the top module.
// TESTING (ROW_DWELL=4, BLANK_CYCLES=1, enable=1 unless stated)
//  1 Reset: hold reset=0 for 3 cycles -> row_sel=0, col_data=0, busy=0, frame_done=0.
//  2 Load: grid=64'h0412_6424_0034_3C28 with a 1-cycle grid_valid ->
//    - rows 0..7 show col_data 28,3C,34,00,24,64,12,04
//    - each row lasts 4 cycles followed by 1 dark cycle
//    - frame_done pulses after 40 cycles; the frame then repeats unchanged.
//  3 Tear-free swap: strobe a second grid (all ones) while row 3 is lit ->
//    - rows 3..7 still show the first grid
//    - a LOAD follows, then every row reads FF.
//  4 Double strobe: two grid_valid pulses within one frame (AA.., then 55..) ->
//    the next frame shows 55 only.
//  5 Disable: drop enable during row 2 -> the frame completes, frame_done pulses,
//    then IDLE with busy=0 and outputs 0.
//  6 Async reset mid-row 5 -> outputs are 0 within the same cycle; no frame_done.
//    After release, scanning restarts only on a new grid_valid.
//  7 (LED_DIM_EN) duty=2 -> col_data is lit for 2 of the 4 dwell cycles per row;
//    duty=0 -> columns stay 0 while row_sel still cycles.

Source files
------------

// File: rtl/grid_pkg.sv
// grid_pkg: shared sizes, grid word type and scan FSM states for the LED grid scan driver.
package grid_pkg;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;

    typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        BLANK
    } scan_state_t;

    // Larger of two integers, used to size the shared dwell/blank counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/grid_scan_driver_if.sv
// grid_scan_driver_if: grid input and LED matrix output bundle of the grid scan driver.
// master = generation controller / board side, slave = the scan driver.
// With LED_DIM_EN defined the bundle also carries the column duty value.
interface grid_scan_driver_if #(
    parameter int ROW_DWELL = 4
);
    import grid_pkg::*;

    logic                 enable;
    grid_t                grid;
    logic                 grid_valid;
    logic [GRID_ROWS-1:0] row_sel;
    logic [GRID_COLS-1:0] col_data;
    logic                 frame_done;
    logic                 busy;

`ifdef LED_DIM_EN
    logic [$clog2(ROW_DWELL+1)-1:0] duty;

    modport master (
        output enable, grid, grid_valid, duty,
        input  row_sel, col_data, frame_done, busy
    );

    modport slave (
        input  enable, grid, grid_valid, duty,
        output row_sel, col_data, frame_done, busy
    );
`else
    modport master (
        output enable, grid, grid_valid,
        input  row_sel, col_data, frame_done, busy
    );

    modport slave (
        input  enable, grid, grid_valid,
        output row_sel, col_data, frame_done, busy
    );
`endif

endinterface

// File: rtl/grid_scan_driver_scan_timer.sv
// scan_timer: loadable down-counter with a terminal-count flag; times both row dwell and blanking.
// The counter holds at zero once reached; tc is high while the count is zero.
// With LED_DIM_EN defined the live count is exported so the top can locate the cycle within a dwell.
module scan_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef LED_DIM_EN
    output logic [WIDTH-1:0] count,
`endif
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    // Reload on request, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);
`ifdef LED_DIM_EN
    assign count = count_reg;
`endif

endmodule

// File: rtl/grid_scan_driver.sv
// grid_scan_driver: scans a 64-bit life grid onto an 8x8 LED matrix, one lit row at a time.
// Incoming grids land in a pending buffer and are swapped into the display buffer only between
// frames, so one frame never mixes two generations. All outputs are registered.
// Optional feature macro: LED_DIM_EN adds a duty input that limits how long columns are lit per row.
module grid_scan_driver
    import grid_pkg::*;
#(
    parameter int ROW_DWELL    = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    grid_scan_driver_if.slave bus
);

    localparam int TMR_W = $clog2(max2(ROW_DWELL, BLANK_CYCLES) + 1);
    localparam int ROW_W = $clog2(GRID_ROWS);
    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(ROW_DWELL - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(GRID_ROWS - 1);

    scan_state_t          state_reg, state_next;
    logic [ROW_W-1:0]     row_reg, row_next;
    grid_t                pend_buf_reg;
    grid_t                disp_buf_reg, disp_next;
    logic                 pending_reg;
    logic                 row_done;
    logic                 frame_end;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_tc;
    logic [GRID_ROWS-1:0] row_sel_reg, row_sel_next;
    logic [GRID_COLS-1:0] col_data_reg, col_data_next;
    logic                 frame_done_reg;
    logic                 busy_reg;

`ifdef LED_DIM_EN
    localparam int DUTY_W = $clog2(ROW_DWELL + 1);
    logic [TMR_W-1:0]  tmr_count;
    logic              show_start;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    int                dwell_idx;
`endif

    // Any state or row change restarts the timer with the length of the phase being entered.
    assign tmr_load = (state_next != state_reg) || (row_next != row_reg);
    assign tmr_val  = (state_next == BLANK) ? BLANK_LOAD : DWELL_LOAD;
`ifdef LED_DIM_EN
    assign show_start = tmr_load && (state_next == SHOW);
`endif

    scan_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
`ifdef LED_DIM_EN
        .count   (tmr_count),
`endif
        .tc      (tmr_tc)
    );

    // State, row, buffers and registered outputs; a new strobe always beats the LOAD clear of pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            pend_buf_reg   <= '0;
            disp_buf_reg   <= '0;
            pending_reg    <= 1'b0;
            row_sel_reg    <= '0;
            col_data_reg   <= '0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef LED_DIM_EN
            duty_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            disp_buf_reg   <= disp_next;
            row_sel_reg    <= row_sel_next;
            col_data_reg   <= col_data_next;
            frame_done_reg <= frame_end;
            busy_reg       <= (state_next != IDLE);
`ifdef LED_DIM_EN
            duty_reg       <= duty_next;
`endif
            if (bus.grid_valid) begin
                pend_buf_reg <= bus.grid;
                pending_reg  <= 1'b1;
            end else if (state_reg == LOAD) begin
                pending_reg  <= 1'b0;
            end
        end
    end

    // Next state: walk rows through SHOW/BLANK; enable and pending are only honoured between frames.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        row_done   = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            IDLE:    if (pending_reg && bus.enable) state_next = LOAD;
            LOAD: begin
                state_next = SHOW;
                row_next   = '0;
            end
            SHOW: begin
                if (tmr_tc) begin
                    if (BLANK_CYCLES > 0) state_next = BLANK;
                    else                  row_done   = 1'b1;
                end
            end
            BLANK:   if (tmr_tc) row_done = 1'b1;
            default: state_next = IDLE;
        endcase
        if (row_done) begin
            if (row_reg == LAST_ROW) begin
                frame_end = 1'b1;
                if (pending_reg && bus.enable) begin
                    state_next = LOAD;
                end else if (!bus.enable) begin
                    state_next = IDLE;
                end else begin
                    state_next = SHOW;
                    row_next   = '0;
                end
            end else begin
                state_next = SHOW;
                row_next   = row_reg + 1'b1;
            end
        end
    end

    // Output decode for the cycle being entered: one-hot row plus that row's byte, dark otherwise.
    always_comb begin
        disp_next     = (state_reg == LOAD) ? pend_buf_reg : disp_buf_reg;
        row_sel_next  = '0;
        col_data_next = '0;
`ifdef LED_DIM_EN
        duty_next = show_start ? bus.duty : duty_reg;
        dwell_idx = show_start ? 0 : (ROW_DWELL - int'(tmr_count));
`endif
        if (state_next == SHOW) begin
            row_sel_next  = GRID_ROWS'(1) << row_next;
            col_data_next = disp_next[{row_next, 3'b000} +: GRID_COLS];
`ifdef LED_DIM_EN
            if (dwell_idx >= int'(duty_next)) col_data_next = '0;
`endif
        end
    end

    assign bus.row_sel    = row_sel_reg;
    assign bus.col_data   = col_data_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_grid_scan_driver.sv
// tb_grid_scan_driver: directed plus randomized checks of grid_scan_driver against a frame-position
// reference model (ROW_DWELL=4, BLANK_CYCLES=1). Define LED_DIM_EN to also exercise column duty.
module tb_grid_scan_driver;

    localparam int D     = 4;
    localparam int B     = 1;
    localparam int PER   = D + B;
    localparam int FRAME = 8 * PER;
    localparam logic [63:0] G1 = 64'h0412_6424_0034_3C28;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    grid_scan_driver_if #(.ROW_DWELL(D)) bus ();

    grid_scan_driver #(
        .ROW_DWELL   (D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    checks = 0;
    int    errors = 0;
    string tag    = "init";
    int    tb_duty = D;

    // Reference model: mode 0 idle, 1 load cycle, 2 scanning at frame position m_pos.
    int          m_mode;
    int          m_pos;
    logic [63:0] m_disp;
    logic [63:0] m_pend;
    bit          m_pv;
    bit          m_fd;
    int          m_duty;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_fd = 0; m_duty = D;
    endtask

    task automatic model_edge(input bit gv, input logic [63:0] g, input bit en, input int duty);
        bit clr;
        clr  = 0;
        m_fd = 0;
        case (m_mode)
            0: if (m_pv && en) m_mode = 1;
            1: begin
                m_mode = 2; m_pos = 0; m_disp = m_pend; clr = 1; m_duty = duty;
            end
            default: begin
                if (m_pos == FRAME - 1) begin
                    m_fd = 1;
                    if (m_pv && en)  m_mode = 1;
                    else if (!en)    m_mode = 0;
                    else begin m_pos = 0; m_duty = duty; end
                end else begin
                    m_pos++;
                    if (m_pos % PER == 0) m_duty = duty;
                end
            end
        endcase
        if (gv) begin m_pend = g; m_pv = 1; end
        else if (clr) m_pv = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s/%s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] er, ec;
        int r, ph;
        er = '0; ec = '0;
        if (m_mode == 2) begin
            r  = m_pos / PER;
            ph = m_pos % PER;
            if (ph < D) begin
                er = 8'(1 << r);
                if (ph < m_duty) ec = m_disp[8*r +: 8];
            end
        end
        chk("row_sel",    64'(bus.row_sel),    64'(er));
        chk("col_data",   64'(bus.col_data),   64'(ec));
        chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
        chk("busy",       64'(bus.busy),       64'(m_mode != 0));
    endtask

    task automatic step(input bit gv, input logic [63:0] g, input bit en);
        bus.grid_valid = gv;
        bus.grid       = g;
        bus.enable     = en;
`ifdef LED_DIM_EN
        bus.duty       = 3'(tb_duty);
`endif
        @(posedge clk);
        model_edge(gv, g, en, tb_duty);
        #1;
        check_outputs();
    endtask

    task automatic run_until_pos(input int p, input bit en);
        for (int i = 0; i < 4 * FRAME && !(m_mode == 2 && m_pos == p); i++) step(0, '0, en);
    endtask

    task automatic run_until_load();
        for (int i = 0; i < 4 * FRAME && m_mode != 1; i++) step(0, '0, 1);
    endtask

    initial begin
        bit          en_r;
        bit          gv_r;
        logic [63:0] g_r;

        model_reset();
        bus.grid_valid = 0; bus.grid = '0; bus.enable = 1;
`ifdef LED_DIM_EN
        bus.duty = 3'(D);
`endif

        // 1: reset held for 3 cycles
        tag = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk("row_sel",    64'(bus.row_sel),    64'h0);
        chk("col_data",   64'(bus.col_data),   64'h0);
        chk("busy",       64'(bus.busy),       64'h0);
        chk("frame_done", 64'(bus.frame_done), 64'h0);
        reset = 1'b1;
        step(0, '0, 1);

        // 2: load, latency of two edges, frame of 40 cycles then repeat
        tag = "load";
        step(1, G1, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("first_row", 64'(bus.row_sel),  64'h01);
        chk("first_col", 64'(bus.col_data), 64'h28);
        for (int k = 1; k < FRAME; k++) step(0, '0, 1);
        step(0, '0, 1);
        chk("frame_done_at_40", 64'(bus.frame_done), 64'h1);
        chk("repeat_col",       64'(bus.col_data),   64'h28);
        run_until_pos(0, 1);

        // 3: tear-free swap while row 3 is lit
        tag = "swap";
        run_until_pos(16, 1);
        step(1, '1, 1);
        run_until_pos(35, 1);
        chk("row7_old_grid", 64'(bus.col_data), 64'h04);
        run_until_load();
        step(0, '0, 1);
        chk("new_grid_row0", 64'(bus.col_data), 64'hFF);

        // 4: double strobe within one frame keeps only the last grid
        tag = "double";
        run_until_pos(5, 1);
        step(1, {8{8'hAA}}, 1);
        run_until_pos(20, 1);
        step(1, {8{8'h55}}, 1);
        run_until_load();
        step(0, '0, 1);
        chk("last_grid_row0", 64'(bus.col_data), 64'h55);

        // 5: disable during row 2 finishes the frame then idles
        tag = "disable";
        run_until_pos(11, 1);
        for (int i = 0; i < 2 * FRAME && m_mode != 0; i++) step(0, '0, 0);
        chk("frame_done_on_stop", 64'(bus.frame_done), 64'h1);
        chk("busy_idle",          64'(bus.busy),       64'h0);
        step(0, '0, 0);
        chk("idle_dark", 64'(bus.row_sel), 64'h0);

        // 6: asynchronous reset during row 5
        tag = "async_reset";
        step(1, G1, 1);
        run_until_pos(27, 1);
        #2 reset = 1'b0;
        #1;
        chk("row_sel_now",    64'(bus.row_sel),    64'h0);
        chk("col_data_now",   64'(bus.col_data),   64'h0);
        chk("busy_now",       64'(bus.busy),       64'h0);
        chk("frame_done_now", 64'(bus.frame_done), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) step(0, '0, 1);
        chk("stays_idle", 64'(bus.busy), 64'h0);
        step(1, G1, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("restart_col", 64'(bus.col_data), 64'h28);

        // Randomized grids, strobes and enable toggles
        tag = "random";
        en_r = 1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 49) == 0) en_r = ~en_r;
            gv_r = ($urandom_range(0, 24) == 0);
            g_r  = {$urandom, $urandom};
`ifdef LED_DIM_EN
            tb_duty = int'($urandom_range(0, D));
`endif
            step(gv_r, g_r, en_r);
        end
        tb_duty = D;
        for (int i = 0; i < 2 * FRAME; i++) step(0, '0, 1);

`ifdef LED_DIM_EN
        // 7: column duty limits lit cycles per row; duty 0 still scans rows
        tag = "dim";
        step(1, {8{8'hC3}}, 1);
        tb_duty = 2;
        run_until_load();
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("duty2_dark_col", 64'(bus.col_data), 64'h0);
        chk("duty2_row",      64'(bus.row_sel),  64'h01);
        for (int i = 0; i < FRAME; i++) step(0, '0, 1);
        tb_duty = 0;
        for (int i = 0; i < 2 * FRAME; i++) step(0, '0, 1);
        tb_duty = D;
        for (int i = 0; i < FRAME; i++) step(0, '0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
